// File: rtl/rx_frame_assembler.sv
// rtl/rx_frame_assembler.sv - sync-header frame assembler with frame-buffer writes, checksum and gap timeout
module rx_frame_assembler #(
  parameter int          FRAME_BYTES  = 1024,
  parameter int          ADDR_W       = 10,
  parameter int          TIMEOUT_CLKS = 12000,
  parameter logic [7:0]  SYNC0        = 8'hA5,
  parameter logic [7:0]  SYNC1        = 8'h5A
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [7:0]        o_Wr_Data,
  output logic              o_Frame_Done,
  output logic              o_Frame_Err,
  output logic              o_Busy
);

  typedef enum logic [1:0] {S_SYNC0, S_SYNC1, S_PAYLOAD, S_CHECK} state_t;

  localparam int                 GAP_W    = $clog2(TIMEOUT_CLKS);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);
  localparam logic [ADDR_W-1:0]  IDX_LAST = ADDR_W'(FRAME_BYTES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [7:0]          sum_q, sum_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                timeout;

  // gap_q is the number of clocks since the last strobe, so the strobe cycle
  // itself counts as one and the terminal count lands TIMEOUT_CLKS-1 clocks later
  assign timeout = (state_q != S_SYNC0) && !i_Rx_DV && (gap_q == GAP_LAST);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    gap_d     = gap_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (state_q != S_SYNC0) begin
      gap_d = i_Rx_DV ? GAP_W'(1) : gap_q + GAP_W'(1);
    end

    case (state_q)
      S_SYNC0: begin
        gap_d = '0;
        if (i_Rx_DV && i_Rx_Byte == SYNC0) begin
          state_d = S_SYNC1;
          gap_d   = GAP_W'(1);
        end
      end
      S_SYNC1: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == SYNC1) begin
            state_d = S_PAYLOAD;
            idx_d   = '0;
            sum_d   = '0;
          end else if (i_Rx_Byte != SYNC0) begin
            state_d = S_SYNC0;
            gap_d   = '0;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_Rx_DV) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = i_Rx_Byte;
          sum_d     = sum_q + i_Rx_Byte;
          idx_d     = idx_q + ADDR_W'(1);
          if (idx_q == IDX_LAST) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (i_Rx_DV) begin
          done_d  = (i_Rx_Byte == sum_q);
          err_d   = (i_Rx_Byte != sum_q);
          state_d = S_SYNC0;
          gap_d   = '0;
        end
      end
      default: state_d = S_SYNC0;
    endcase

    if (timeout) begin
      state_d = S_SYNC0;
      err_d   = 1'b1;
      gap_d   = '0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_SYNC0;
      idx_q     <= '0;
      sum_q     <= '0;
      gap_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      gap_q     <= gap_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_Wr_En      = wr_en_q;
  assign o_Wr_Addr    = wr_addr_q;
  assign o_Wr_Data    = wr_data_q;
  assign o_Frame_Done = done_q;
  assign o_Frame_Err  = err_q;
  assign o_Busy       = (state_q != S_SYNC0);

endmodule

// File: tb/tb_rx_frame_assembler.sv
// tb/tb_rx_frame_assembler.sv - scoreboard bench for rx_frame_assembler
module tb_rx_frame_assembler;

  localparam int FRAME_BYTES  = 4;
  localparam int ADDR_W       = 2;
  localparam int TIMEOUT_CLKS = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              dv;
  logic [7:0]        rx_byte;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_done;
  logic              frame_err;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [ADDR_W+7:0] exp_q[$];
  logic              last_done, last_err, last_busy;

  rx_frame_assembler #(
    .FRAME_BYTES (FRAME_BYTES),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CLKS(TIMEOUT_CLKS),
    .SYNC0       (8'hA5),
    .SYNC1       (8'h5A)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Rx_DV     (dv),
    .i_Rx_Byte   (rx_byte),
    .o_Wr_En     (wr_en),
    .o_Wr_Addr   (wr_addr),
    .o_Wr_Data   (wr_data),
    .o_Frame_Done(frame_done),
    .o_Frame_Err (frame_err),
    .o_Busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Write scoreboard and pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(wr_en), 32'd0);
      end else begin
        logic [ADDR_W+7:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+7:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  // Caller is at a falling edge; captures outputs one cycle after the strobe
  task automatic send(input logic [7:0] b, input int idle);
    dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    dv = 1'b0;
    last_done = frame_done;
    last_err  = frame_err;
    last_busy = busy;
    repeat (idle) @(negedge clk);
  endtask

  task automatic send_frame(input string tag, input logic [31:0] payload,
                            input logic corrupt, input int idle);
    logic [7:0] sum;
    logic [7:0] b;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    sum = 8'h00;
    send(8'hA5, idle);
    send(8'h5A, idle);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      b = payload[31-8*i -: 8];
      exp_q.push_back({ADDR_W'(i), b});
      sum = sum + b;
      send(b, idle);
    end
    send(corrupt ? sum + 8'h01 : sum, 0);
    check({tag, "_done"}, 32'(last_done), 32'(!corrupt));
    check({tag, "_err"},  32'(last_err),  32'(corrupt));
    check({tag, "_busy"}, 32'(last_busy), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'(!corrupt));
    check({tag, "_err_cnt"},  32'(err_cnt - e0),  32'(corrupt));
  endtask

  initial begin
    int t;
    int e0, d0;
    rst = 1'b1;
    dv = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send_frame("good", 32'h01020304, 1'b0, 4);
    send_frame("badchk", 32'h01020304, 1'b1, 4);

    send(8'h00, 2);
    check("sync0_ignore_busy", 32'(last_busy), 32'd0);
    send(8'hA5, 2);
    check("sync1_busy", 32'(last_busy), 32'd1);
    send_frame("resync", 32'h10203040, 1'b0, 2);

    e0 = err_cnt;
    send(8'hA5, 2);
    send(8'h33, 2);
    check("abort_busy", 32'(last_busy), 32'd0);
    check("abort_no_err", 32'(err_cnt - e0), 32'd0);

    e0 = err_cnt;
    send(8'hA5, 1);
    send(8'h5A, 1);
    exp_q.push_back({2'd0, 8'h01});
    send(8'h01, 1);
    exp_q.push_back({2'd1, 8'h02});
    send(8'h02, 0);
    t = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (frame_err) begin
        t = i;
        break;
      end
    end
    check("timeout_latency", 32'(t), 32'd19);
    @(negedge clk);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("timeout_writes_left", 32'(exp_q.size()), 32'd0);
    send_frame("after_timeout", 32'h05060708, 1'b0, 1);

    send_frame("b2b", 32'hA55AFF01, 1'b0, 0);

    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hA5, 1);
    send(8'h5A, 1);
    exp_q.push_back({2'd0, 8'h11});
    send(8'h11, 1);
    exp_q.push_back({2'd1, 8'h22});
    send(8'h22, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    send(8'h33, 1);
    send(8'h44, 1);
    repeat (3) @(negedge clk);
    check("rst_mid_writes_left", 32'(exp_q.size()), 32'd0);
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_mid_no_err", 32'(err_cnt - e0), 32'd0);
    send_frame("after_rst", 32'hDEADBEEF, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
